// File: rtl/fxp_quotient_round_sat_if.sv
// Handshake and data bundle between the long divider, the quotient output stage and its consumer.
// master = divider/consumer side (testbench), slave = fxp_quotient_round_sat.
interface fxp_quotient_round_sat_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_quotient;
  logic [DATA_W-1:0] i_remainder;
  logic [DATA_W-1:0] i_divisor;
  logic              i_dbz;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_sat;
  logic              o_dbz;
  logic [CNT_W-1:0]  o_dbz_count;

  modport master (
    output i_valid, i_quotient, i_remainder, i_divisor, i_dbz, i_ready,
    input  o_ready, o_valid, o_data, o_sat, o_dbz, o_dbz_count
  );

  modport slave (
    input  i_valid, i_quotient, i_remainder, i_divisor, i_dbz, i_ready,
    output o_ready, o_valid, o_data, o_sat, o_dbz, o_dbz_count
  );
endinterface

// File: rtl/fxp_quotient_round_sat.sv
// Rounds (half-up) and saturates the divider quotient through a 2-stage valid/ready pipeline.
// Define QUOTIENT_ROUND_EN to enable rounding; otherwise the quotient is truncated.
module fxp_quotient_round_sat #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int CNT_W  = 8
) (
  input logic                     i_clk,
  input logic                     i_reset,
  fxp_quotient_round_sat_if.slave bus
);

  if (FRAC_W < 0 || FRAC_W > DATA_W) begin : gBadFracW
    $error("FRAC_W must lie in 0..DATA_W");
  end

  logic              s1Valid_q, s1Valid_d;
  logic [DATA_W-1:0] s1Quot_q, s1Quot_d;
  logic              s1Dbz_q, s1Dbz_d;
  logic              s1Rnd_q, s1Rnd_d;
  logic              s2Valid_q, s2Valid_d;
  logic [DATA_W-1:0] s2Data_q, s2Data_d;
  logic              s2Sat_q, s2Sat_d;
  logic              s2Dbz_q, s2Dbz_d;
  logic [CNT_W-1:0]  dbzCount_q, dbzCount_d;

  logic              rnd;
  logic              s2Free;
  logic              inXfer;
  logic              acceptOk;
  logic [DATA_W:0]   sum;

`ifdef QUOTIENT_ROUND_EN
  // Doubling the remainder into DATA_W+1 bits keeps the half-LSB compare overflow-free.
  assign rnd = ({bus.i_remainder, 1'b0} >= {1'b0, bus.i_divisor});
`else
  logic unusedRoundInputs;
  assign unusedRoundInputs = ^{bus.i_remainder, bus.i_divisor};
  assign rnd = 1'b0;
`endif

  assign s2Free   = !s2Valid_q || bus.i_ready;
  assign acceptOk = !s1Valid_q || s2Free;
  assign inXfer   = bus.i_valid && acceptOk;
  assign sum      = {1'b0, s1Quot_q} + {{DATA_W{1'b0}}, s1Rnd_q};

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Quot_d   = s1Quot_q;
    s1Dbz_d    = s1Dbz_q;
    s1Rnd_d    = s1Rnd_q;
    s2Valid_d  = s2Valid_q;
    s2Data_d   = s2Data_q;
    s2Sat_d    = s2Sat_q;
    s2Dbz_d    = s2Dbz_q;
    dbzCount_d = dbzCount_q;

    if (s2Free) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        if (s1Dbz_q) begin
          s2Data_d = '1;
          s2Sat_d  = 1'b1;
          s2Dbz_d  = 1'b1;
        end else if (sum[DATA_W]) begin
          s2Data_d = '1;
          s2Sat_d  = 1'b1;
          s2Dbz_d  = 1'b0;
        end else begin
          s2Data_d = sum[DATA_W-1:0];
          s2Sat_d  = 1'b0;
          s2Dbz_d  = 1'b0;
        end
      end
    end

    // A new input may land in stage 1 in the same cycle its old content moves on.
    if (inXfer) begin
      s1Valid_d = 1'b1;
      s1Quot_d  = bus.i_quotient;
      s1Dbz_d   = bus.i_dbz;
      s1Rnd_d   = rnd;
    end else if (s2Free) begin
      s1Valid_d = 1'b0;
    end

    if (inXfer && bus.i_dbz && (dbzCount_q != '1)) begin
      dbzCount_d = dbzCount_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1Valid_q  <= 1'b0;
      s1Quot_q   <= '0;
      s1Dbz_q    <= 1'b0;
      s1Rnd_q    <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Data_q   <= '0;
      s2Sat_q    <= 1'b0;
      s2Dbz_q    <= 1'b0;
      dbzCount_q <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Quot_q   <= s1Quot_d;
      s1Dbz_q    <= s1Dbz_d;
      s1Rnd_q    <= s1Rnd_d;
      s2Valid_q  <= s2Valid_d;
      s2Data_q   <= s2Data_d;
      s2Sat_q    <= s2Sat_d;
      s2Dbz_q    <= s2Dbz_d;
      dbzCount_q <= dbzCount_d;
    end
  end

  assign bus.o_ready     = acceptOk;
  assign bus.o_valid     = s2Valid_q;
  assign bus.o_data      = s2Data_q;
  assign bus.o_sat       = s2Sat_q;
  assign bus.o_dbz       = s2Dbz_q;
  assign bus.o_dbz_count = dbzCount_q;

endmodule
